// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : atm_pkg
//  Description : Shared encodings for the ATM session controller: FSM state
//                codes, display codes, menu selections and the state-to-display
//                mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    // FSM state encodings
    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_load_bal = 4'd1;
    localparam logic [3:0] c_st_wait_pin = 4'd2;
    localparam logic [3:0] c_st_bad_pin  = 4'd3;
    localparam logic [3:0] c_st_menu     = 4'd4;
    localparam logic [3:0] c_st_wait_amt = 4'd5;
    localparam logic [3:0] c_st_err      = 4'd6;
    localparam logic [3:0] c_st_dispense = 4'd7;
    localparam logic [3:0] c_st_receipt  = 4'd8;
    localparam logic [3:0] c_st_done     = 4'd9;
    localparam logic [3:0] c_st_eject    = 4'd10;
    localparam logic [3:0] c_st_retain   = 4'd11;
    localparam logic [3:0] c_st_tmo      = 4'd12;

    // Front-panel display codes
    localparam logic [2:0] c_disp_welcome  = 3'b000;
    localparam logic [2:0] c_disp_proc     = 3'b001;
    localparam logic [2:0] c_disp_enter    = 3'b010;
    localparam logic [2:0] c_disp_select   = 3'b011;
    localparam logic [2:0] c_disp_success  = 3'b101;
    localparam logic [2:0] c_disp_error    = 3'b111;
    localparam logic [2:0] c_disp_retained = 3'b110;
    localparam logic [2:0] c_disp_timeout  = 3'b100;

    // Menu selections
    localparam logic [1:0] c_sel_withdraw = 2'b00;
    localparam logic [1:0] c_sel_balance  = 2'b01;
    localparam logic [1:0] c_sel_mini     = 2'b10;
    localparam logic [1:0] c_sel_exit     = 2'b11;

    // Display code shown while the FSM sits in a given state
    function automatic logic [2:0] state_display(input logic [3:0] st);
        logic [2:0] d;
        d = c_disp_welcome;
        case (st)
            c_st_idle:     d = c_disp_welcome;
            c_st_load_bal: d = c_disp_proc;
            c_st_wait_pin: d = c_disp_enter;
            c_st_bad_pin:  d = c_disp_error;
            c_st_menu:     d = c_disp_select;
            c_st_wait_amt: d = c_disp_enter;
            c_st_err:      d = c_disp_error;
            c_st_dispense: d = c_disp_proc;
            c_st_receipt:  d = c_disp_proc;
            c_st_done:     d = c_disp_success;
            c_st_eject:    d = c_disp_proc;
            c_st_retain:   d = c_disp_retained;
            c_st_tmo:      d = c_disp_timeout;
            default:       d = c_disp_welcome;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : atm_timeout_timer
//  Description : Inactivity down-counter. load reloads TIMEOUT_CYC; enable
//                counts down; expire flags the last allowed idle cycle so the
//                FSM leaves the wait state on the edge where the count hits 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Reload has priority; otherwise count down while the FSM is waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_reload;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign expire = enable && (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : atm_session_ctrl
//  Description : ATM session controller. Loads the host balance, checks the
//                PIN with a retry limit and card retention, serves a 4-way
//                menu with a per-session transaction limit, and ejects the
//                card on exit or inactivity. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int AMT_W         = 16,
    parameter int BAL_W         = 24,
    parameter int MAX_PIN_TRIES = 3,
    parameter int TIMEOUT_CYC   = 1000,
    parameter int MAX_TXN       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_in,
    input  logic             bal_valid,
    input  logic [BAL_W-1:0] bal_in,
    input  logic             pin_valid,
    input  logic             pin_ok,
    input  logic             menu_valid,
    input  logic [1:0]       menu_sel,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amt,
    input  logic             new_txn,
    output logic             cash_out,
    output logic [AMT_W-1:0] cash_amt,
    output logic             receipt_out,
    output logic [BAL_W-1:0] balance_out,
    output logic             card_eject,
    output logic             card_retain,
    output logic [2:0]       display,
    output logic             busy
);

    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
    localparam int TXN_W = $clog2(MAX_TXN + 1);
    localparam logic [TRY_W-1:0] c_max_tries = TRY_W'(MAX_PIN_TRIES);
    localparam logic [TXN_W-1:0] c_max_txn   = TXN_W'(MAX_TXN);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [BAL_W-1:0] r_balance;
    logic [AMT_W-1:0] r_amt;
    logic [TRY_W-1:0] r_tries;
    logic [TXN_W-1:0] r_txn_cnt;

    logic [TRY_W-1:0] w_tries_inc;
    logic [TXN_W-1:0] w_txn_inc;
    logic [BAL_W-1:0] w_amt_ext;
    logic             w_amt_bad;
    logic             w_wait_state;
    logic             w_tmr_load;
    logic             w_expire;

    assign w_tries_inc  = r_tries + TRY_W'(1);
    assign w_txn_inc    = r_txn_cnt + TXN_W'(1);
    assign w_amt_ext    = BAL_W'(amt);
    assign w_amt_bad    = (amt == '0) || (w_amt_ext > r_balance);
    assign w_wait_state = (r_state == c_st_load_bal) || (r_state == c_st_wait_pin) ||
                          (r_state == c_st_menu)     || (r_state == c_st_wait_amt);
    // Every accepted strobe moves the FSM, so a state change covers both
    // wait-state entry and strobe acceptance.
    assign w_tmr_load   = (w_next != r_state);

    atm_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_tmr_load),
        .enable (w_wait_state),
        .expire (w_expire)
    );

    // Next-state logic; a relevant strobe always wins over an expiring timer
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (card_in) w_next = c_st_load_bal;
            end
            c_st_load_bal: begin
                if (bal_valid)     w_next = c_st_wait_pin;
                else if (w_expire) w_next = c_st_tmo;
            end
            c_st_wait_pin: begin
                if (pin_valid) begin
                    if (pin_ok)                          w_next = c_st_menu;
                    else if (w_tries_inc == c_max_tries) w_next = c_st_retain;
                    else                                 w_next = c_st_bad_pin;
                end else if (w_expire) begin
                    w_next = c_st_tmo;
                end
            end
            c_st_bad_pin: w_next = c_st_wait_pin;
            c_st_menu: begin
                if (menu_valid) begin
                    case (menu_sel)
                        c_sel_withdraw: w_next = c_st_wait_amt;
                        c_sel_balance:  w_next = c_st_receipt;
                        c_sel_mini:     w_next = c_st_receipt;
                        c_sel_exit:     w_next = c_st_eject;
                        default:        w_next = c_st_eject;
                    endcase
                end else if (w_expire) begin
                    w_next = c_st_tmo;
                end
            end
            c_st_wait_amt: begin
                if (amt_valid)     w_next = w_amt_bad ? c_st_err : c_st_dispense;
                else if (w_expire) w_next = c_st_tmo;
            end
            c_st_err:      w_next = c_st_menu;
            c_st_dispense: w_next = c_st_done;
            c_st_receipt:  w_next = c_st_done;
            c_st_done: begin
                if ((w_txn_inc == c_max_txn) || !new_txn) w_next = c_st_eject;
                else                                      w_next = c_st_menu;
            end
            c_st_eject:  w_next = c_st_idle;
            c_st_retain: w_next = c_st_idle;
            c_st_tmo:    w_next = c_st_eject;
            default:     w_next = c_st_idle;
        endcase
    end

    // State, balance, PIN-try and transaction registers; IDLE wipes the session
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_balance <= '0;
            r_amt     <= '0;
            r_tries   <= '0;
            r_txn_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_st_idle: begin
                    r_balance <= '0;
                    r_tries   <= '0;
                    r_txn_cnt <= '0;
                end
                c_st_load_bal: begin
                    if (bal_valid) r_balance <= bal_in;
                end
                c_st_wait_pin: begin
                    if (pin_valid) r_tries <= pin_ok ? '0 : w_tries_inc;
                end
                c_st_wait_amt: begin
                    if (amt_valid) r_amt <= amt;
                end
                c_st_dispense: r_balance <= r_balance - BAL_W'(r_amt);
                c_st_done:     r_txn_cnt <= w_txn_inc;
                default: ;
            endcase
        end
    end

    // Output registers: pulses and display follow the state one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cash_out    <= 1'b0;
            cash_amt    <= '0;
            receipt_out <= 1'b0;
            balance_out <= '0;
            card_eject  <= 1'b0;
            card_retain <= 1'b0;
            display     <= c_disp_welcome;
            busy        <= 1'b0;
        end else begin
            cash_out    <= (r_state == c_st_dispense);
            receipt_out <= (r_state == c_st_receipt);
            card_eject  <= (r_state == c_st_eject);
            card_retain <= (r_state == c_st_retain);
            display     <= state_display(r_state);
            busy        <= (r_state != c_st_idle);
            if (r_state == c_st_dispense) cash_amt    <= r_amt;
            if (r_state == c_st_receipt)  balance_out <= r_balance;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_atm_session_ctrl
//  Description : Self-checking bench for atm_session_ctrl. Expected pulse
//                events are queued as stimulus is driven and matched against
//                the DUT pulses as they appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_session_ctrl;

    localparam int TMO_CYC = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_in, bal_valid, pin_valid, pin_ok, menu_valid, amt_valid, new_txn;
    logic [23:0] bal_in;
    logic [1:0]  menu_sel;
    logic [15:0] amt;
    logic        cash_out, receipt_out, card_eject, card_retain, busy;
    logic [15:0] cash_amt;
    logic [23:0] balance_out;
    logic [2:0]  display;

    int n_checks = 0;
    int n_pass   = 0;
    logic [26:0] sb_q[$];

    atm_session_ctrl #(
        .AMT_W(16), .BAL_W(24), .MAX_PIN_TRIES(3), .TIMEOUT_CYC(TMO_CYC), .MAX_TXN(4)
    ) dut (
        .clk(clk), .reset(reset), .card_in(card_in), .bal_valid(bal_valid), .bal_in(bal_in),
        .pin_valid(pin_valid), .pin_ok(pin_ok), .menu_valid(menu_valid), .menu_sel(menu_sel),
        .amt_valid(amt_valid), .amt(amt), .new_txn(new_txn), .cash_out(cash_out),
        .cash_amt(cash_amt), .receipt_out(receipt_out), .balance_out(balance_out),
        .card_eject(card_eject), .card_retain(card_retain), .display(display), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Event encoding: 1 cash, 2 receipt, 3 eject, 4 retain
    function automatic logic [26:0] ev(input logic [2:0] k, input logic [23:0] v);
        return {k, v};
    endfunction

    task automatic sb_pop(input logic [26:0] got);
        logic [26:0] e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(got), 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_event", 32'(got), 32'(e));
        end
    endtask

    // Pulse monitor: every DUT pulse must match the next queued expectation
    always @(negedge clk) begin
        if (cash_out)    sb_pop(ev(3'd1, 24'(cash_amt)));
        if (receipt_out) sb_pop(ev(3'd2, balance_out));
        if (card_eject)  sb_pop(ev(3'd3, 24'd0));
        if (card_retain) sb_pop(ev(3'd4, 24'd0));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_disp(input string tag, input logic [2:0] code);
        for (int n = 0; n < 100 && display !== code; n++) tick();
        check(tag, 32'(display), 32'(code));
    endtask

    task automatic do_card();
        card_in = 1'b1; tick(); card_in = 1'b0; tick();
    endtask
    task automatic do_bal(input logic [23:0] b);
        bal_in = b; bal_valid = 1'b1; tick(); bal_valid = 1'b0; tick();
    endtask
    task automatic do_pin(input logic ok);
        pin_ok = ok; pin_valid = 1'b1; tick(); pin_valid = 1'b0; tick();
    endtask
    task automatic do_menu(input logic [1:0] s);
        menu_sel = s; menu_valid = 1'b1; tick(); menu_valid = 1'b0; tick();
    endtask
    task automatic do_amt(input logic [15:0] a);
        amt = a; amt_valid = 1'b1; tick(); amt_valid = 1'b0; tick();
    endtask

    // Card in, balance loaded, good PIN; returns with the menu just displayed
    task automatic start_session(input logic [23:0] b);
        do_card();
        wait_disp("disp_load", 3'b001);
        do_bal(b);
        wait_disp("disp_pin", 3'b010);
        do_pin(1'b1);
        wait_disp("disp_menu", 3'b011);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        card_in = 0; bal_valid = 0; pin_valid = 0; pin_ok = 0; menu_valid = 0;
        amt_valid = 0; new_txn = 0; bal_in = '0; menu_sel = '0; amt = '0;
        tick(); tick();
        check("rst_display", 32'(display), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({cash_out, receipt_out, card_eject, card_retain}), 32'd0);
        check("rst_cash_amt", 32'(cash_amt), 32'd0);
        check("rst_balance", 32'(balance_out), 32'd0);
        reset = 1'b0;
        tick(); tick();
        check("idle_display", 32'(display), 32'd0);

        // 1: withdraw 200 from 500, query balance, exit
        start_session(24'd500);
        check("busy_session", 32'(busy), 32'd1);
        new_txn = 1'b1;
        sb_q.push_back(ev(3'd1, 24'd200));
        do_menu(2'b00);
        check("disp_amt", 32'(display), 32'b010);
        do_amt(16'd200);
        wait_disp("disp_menu2", 3'b011);
        new_txn = 1'b0;
        sb_q.push_back(ev(3'd2, 24'd300));
        sb_q.push_back(ev(3'd3, 24'd0));
        do_menu(2'b01);
        wait_disp("t1_idle", 3'b000);

        // 2: three bad PINs -> retention; first one also carries a menu strobe
        do_card();
        wait_disp("t2_load", 3'b001);
        do_bal(24'd1000);
        wait_disp("t2_pin", 3'b010);
        pin_ok = 1'b0; pin_valid = 1'b1; menu_sel = 2'b11; menu_valid = 1'b1;
        tick();
        pin_valid = 1'b0; menu_valid = 1'b0;
        tick();
        check("pin_bad1", 32'(display), 32'b111);
        tick();
        check("pin_retry1", 32'(display), 32'b010);
        do_pin(1'b0);
        check("pin_bad2", 32'(display), 32'b111);
        tick();
        check("pin_retry2", 32'(display), 32'b010);
        sb_q.push_back(ev(3'd4, 24'd0));
        do_pin(1'b0);
        check("retain_disp", 32'(display), 32'b110);
        tick();
        check("retain_idle_disp", 32'(display), 32'd0);
        check("retain_idle_busy", 32'(busy), 32'd0);

        // 3: overdraw and zero amount rejected, balance intact
        start_session(24'd100);
        do_menu(2'b00);
        do_amt(16'd150);
        check("overdraw_err", 32'(display), 32'b111);
        tick();
        check("overdraw_menu", 32'(display), 32'b011);
        do_menu(2'b00);
        do_amt(16'd0);
        check("zero_amt_err", 32'(display), 32'b111);
        tick();
        check("zero_amt_menu", 32'(display), 32'b011);
        new_txn = 1'b0;
        sb_q.push_back(ev(3'd2, 24'd100));
        sb_q.push_back(ev(3'd3, 24'd0));
        do_menu(2'b10);
        wait_disp("t3_idle", 3'b000);

        // 4a: idle in MENU for TIMEOUT_CYC cycles -> timeout then eject
        start_session(24'd10);
        repeat (TMO_CYC - 1) tick();
        check("tmo_pre", 32'(display), 32'b011);
        sb_q.push_back(ev(3'd3, 24'd0));
        tick();
        check("tmo_disp", 32'(display), 32'b100);
        wait_disp("t4a_idle", 3'b000);

        // 4b: strobe in the expiry cycle wins over the timeout
        start_session(24'd42);
        new_txn = 1'b0;
        repeat (TMO_CYC - 2) tick();
        sb_q.push_back(ev(3'd2, 24'd42));
        sb_q.push_back(ev(3'd3, 24'd0));
        do_menu(2'b01);
        check("tmo_strobe_wins", 32'(display), 32'b001);
        wait_disp("t4b_idle", 3'b000);

        // 5: MAX_TXN enquiries with new_txn held high -> forced eject
        start_session(24'd77);
        new_txn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(ev(3'd2, 24'd77));
            if (i == 3) sb_q.push_back(ev(3'd3, 24'd0));
            do_menu(2'b01);
            if (i < 3) wait_disp("t5_menu", 3'b011);
        end
        wait_disp("t5_idle", 3'b000);
        check("t5_busy", 32'(busy), 32'd0);
        new_txn = 1'b0;

        // 6: reset as DISPENSE is entered aborts with no pulses
        start_session(24'd400);
        do_menu(2'b00);
        amt = 16'd400; amt_valid = 1'b1;
        tick();
        amt_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_pulses", 32'({cash_out, receipt_out, card_eject, card_retain}), 32'd0);
        check("abort_cash_amt", 32'(cash_amt), 32'd0);
        check("abort_display", 32'(display), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_disp", 32'(display), 32'd0);

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
